// File: rtl/png_chunk_chk_pkg.sv
// Shared constants, parser state encoding and the byte-wise CRC-32 step used by png_chunk_chk.
package png_chunk_chk_pkg;

  typedef enum logic [2:0] {
    StSig,
    StLen,
    StType,
    StData,
    StCrc,
    StErr,
    StDone
  } state_e;

  localparam logic [63:0] PNG_SIG   = 64'h8950_4E47_0D0A_1A0A;
  localparam logic [31:0] TYPE_IEND = 32'h4945_4E44;
  localparam logic [31:0] CRC_INIT  = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY  = 32'hEDB8_8320;

  // Byte idx of the signature, idx 0 is the first byte on the wire.
  function automatic logic [7:0] sig_byte(input logic [2:0] idx);
    int unsigned sh;
    sh = 32'd8 * (32'd7 - 32'(idx));
    return PNG_SIG[sh +: 8];
  endfunction

  // Reflected CRC-32 over one byte, LSB first; register holds the un-inverted remainder.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/png_crc32.sv
// Byte-wise CRC-32 engine: init has priority over a coincident data byte.
module png_crc32
  import png_chunk_chk_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        i_crc_init,
  input  logic [7:0]  i_data_in,
  input  logic        i_data_in_vld,
  output logic [31:0] o_crc_out
);

  logic [31:0] r_crc;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_crc <= CRC_INIT;
    end else if (i_crc_init) begin
      r_crc <= CRC_INIT;
    end else if (i_data_in_vld) begin
      r_crc <= crc32_byte(r_crc, i_data_in);
    end
  end

  assign o_crc_out = r_crc;

endmodule

// File: rtl/png_chunk_chk.sv
// Receive-side PNG chunk parser with CRC-32 check. Define PNG_SIG_CHK_EN to require the
// 8-byte PNG signature ahead of the first chunk.
module png_chunk_chk
  import png_chunk_chk_pkg::*;
#(
  parameter logic [31:0] MAX_LEN = 32'h7FFF_FFFF
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        i_chk_init,
  input  logic [7:0]  i_data_in,
  input  logic        i_data_in_vld,
  output logic [31:0] o_chunk_len,
  output logic [31:0] o_chunk_type,
  output logic        o_hdr_vld,
  output logic [7:0]  o_pld_data,
  output logic        o_pld_vld,
  output logic        o_pld_last,
  output logic        o_chunk_done,
  output logic        o_crc_ok,
  output logic        o_crc_err,
  output logic        o_iend_det,
  output logic        o_fmt_err
);

`ifdef PNG_SIG_CHK_EN
  localparam state_e START_ST = StSig;
`else
  localparam state_e START_ST = StLen;
`endif

  state_e      r_state, w_state_nxt;
  logic [1:0]  r_fcnt, w_fcnt_nxt;
  logic [31:0] r_shift, w_shift_nxt;
  logic [30:0] r_pcnt, w_pcnt_nxt;
  logic [31:0] r_len, w_len_nxt;
  logic [31:0] r_type, w_type_nxt;
  logic        r_hdr, w_hdr_nxt;
  logic [7:0]  r_pld_data, w_pld_data_nxt;
  logic        r_pld_vld, w_pld_vld_nxt;
  logic        r_pld_last, w_pld_last_nxt;
  logic        r_done, w_done_nxt;
  logic        r_ok, w_ok_nxt;
  logic        r_err, w_err_nxt;
  logic        r_iend, w_iend_nxt;
  logic        r_fmt, w_fmt_nxt;
`ifdef PNG_SIG_CHK_EN
  logic [2:0]  r_sig_idx, w_sig_idx_nxt;
`endif

  logic [31:0] w_word;
  logic [31:0] w_crc_reg;
  logic        w_crc_match;
  logic        w_reseed;
  logic        w_crc_init;
  logic        w_crc_vld;

  assign w_word      = {r_shift[23:0], i_data_in};
  assign w_crc_match = (w_word == ~w_crc_reg);
  assign w_crc_init  = i_chk_init | w_reseed;
  assign w_crc_vld   = i_data_in_vld & ((r_state == StType) | (r_state == StData));

  png_crc32 u_crc (
    .clk           (clk),
    .rstn          (rstn),
    .i_crc_init    (w_crc_init),
    .i_data_in     (i_data_in),
    .i_data_in_vld (w_crc_vld),
    .o_crc_out     (w_crc_reg)
  );

  always_comb begin
    w_state_nxt    = r_state;
    w_fcnt_nxt     = r_fcnt;
    w_shift_nxt    = r_shift;
    w_pcnt_nxt     = r_pcnt;
    w_len_nxt      = r_len;
    w_type_nxt     = r_type;
    w_hdr_nxt      = 1'b0;
    w_pld_data_nxt = r_pld_data;
    w_pld_vld_nxt  = 1'b0;
    w_pld_last_nxt = 1'b0;
    w_done_nxt     = 1'b0;
    w_ok_nxt       = r_ok;
    w_err_nxt      = 1'b0;
    w_iend_nxt     = r_iend;
    w_fmt_nxt      = r_fmt;
    w_reseed       = 1'b0;
`ifdef PNG_SIG_CHK_EN
    w_sig_idx_nxt  = r_sig_idx;
`endif

    if (i_chk_init) begin
      w_state_nxt    = START_ST;
      w_fcnt_nxt     = '0;
      w_shift_nxt    = '0;
      w_pcnt_nxt     = '0;
      w_len_nxt      = '0;
      w_type_nxt     = '0;
      w_pld_data_nxt = '0;
      w_ok_nxt       = 1'b0;
      w_iend_nxt     = 1'b0;
      w_fmt_nxt      = 1'b0;
`ifdef PNG_SIG_CHK_EN
      w_sig_idx_nxt  = '0;
`endif
    end else if (i_data_in_vld) begin
      case (r_state)
`ifdef PNG_SIG_CHK_EN
        StSig: begin
          w_sig_idx_nxt = r_sig_idx + 3'd1;
          if (i_data_in != sig_byte(r_sig_idx)) begin
            w_fmt_nxt   = 1'b1;
            w_state_nxt = StErr;
          end else if (r_sig_idx == 3'd7) begin
            w_state_nxt = StLen;
          end
        end
`endif
        StLen: begin
          w_shift_nxt = w_word;
          w_fcnt_nxt  = r_fcnt + 2'd1;
          if (r_fcnt == 2'd3) begin
            if (w_word > MAX_LEN) begin
              w_fmt_nxt   = 1'b1;
              w_state_nxt = StErr;
            end else begin
              // Payload counter doubles as length storage until the header is published.
              w_pcnt_nxt  = w_word[30:0];
              w_state_nxt = StType;
            end
          end
        end
        StType: begin
          w_shift_nxt = w_word;
          w_fcnt_nxt  = r_fcnt + 2'd1;
          if (r_fcnt == 2'd3) begin
            w_type_nxt  = w_word;
            w_len_nxt   = {1'b0, r_pcnt};
            w_hdr_nxt   = 1'b1;
            w_state_nxt = (r_pcnt != '0) ? StData : StCrc;
          end
        end
        StData: begin
          w_pld_data_nxt = i_data_in;
          w_pld_vld_nxt  = 1'b1;
          w_pld_last_nxt = (r_pcnt == 31'd1);
          w_pcnt_nxt     = r_pcnt - 31'd1;
          if (r_pcnt == 31'd1) begin
            w_state_nxt = StCrc;
          end
        end
        StCrc: begin
          w_shift_nxt = w_word;
          w_fcnt_nxt  = r_fcnt + 2'd1;
          if (r_fcnt == 2'd3) begin
            w_done_nxt = 1'b1;
            w_ok_nxt   = w_crc_match;
            w_err_nxt  = ~w_crc_match;
            w_reseed   = 1'b1;
            if (w_crc_match && (r_type == TYPE_IEND)) begin
              w_iend_nxt  = 1'b1;
              w_state_nxt = StDone;
            end else begin
              w_state_nxt = StLen;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= START_ST;
      r_fcnt     <= '0;
      r_shift    <= '0;
      r_pcnt     <= '0;
      r_len      <= '0;
      r_type     <= '0;
      r_hdr      <= 1'b0;
      r_pld_data <= '0;
      r_pld_vld  <= 1'b0;
      r_pld_last <= 1'b0;
      r_done     <= 1'b0;
      r_ok       <= 1'b0;
      r_err      <= 1'b0;
      r_iend     <= 1'b0;
      r_fmt      <= 1'b0;
`ifdef PNG_SIG_CHK_EN
      r_sig_idx  <= '0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_fcnt     <= w_fcnt_nxt;
      r_shift    <= w_shift_nxt;
      r_pcnt     <= w_pcnt_nxt;
      r_len      <= w_len_nxt;
      r_type     <= w_type_nxt;
      r_hdr      <= w_hdr_nxt;
      r_pld_data <= w_pld_data_nxt;
      r_pld_vld  <= w_pld_vld_nxt;
      r_pld_last <= w_pld_last_nxt;
      r_done     <= w_done_nxt;
      r_ok       <= w_ok_nxt;
      r_err      <= w_err_nxt;
      r_iend     <= w_iend_nxt;
      r_fmt      <= w_fmt_nxt;
`ifdef PNG_SIG_CHK_EN
      r_sig_idx  <= w_sig_idx_nxt;
`endif
    end
  end

  assign o_chunk_len  = r_len;
  assign o_chunk_type = r_type;
  assign o_hdr_vld    = r_hdr;
  assign o_pld_data   = r_pld_data;
  assign o_pld_vld    = r_pld_vld;
  assign o_pld_last   = r_pld_last;
  assign o_chunk_done = r_done;
  assign o_crc_ok     = r_ok;
  assign o_crc_err    = r_err;
  assign o_iend_det   = r_iend;
  assign o_fmt_err    = r_fmt;

endmodule
